// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and strobes, and traps on bad opcodes or memory stalls.
module mc_ctrl #(
   parameter int unsigned WAIT_MAX   = 16,
   parameter logic [1:0]  PC_INC_CON = 2'b11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_con,
   output logic [1:0] pc_source,
   output logic       illegal,
   output logic       timeout,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      INIT     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WB   = 4'd5,
      MEM_WR   = 4'd6,
      EXEC     = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      ADDI_EX  = 4'd11,
      ADDI_WB  = 4'd12,
      TRAP     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;

   localparam logic [4:0] WAIT_LAST = 5'(WAIT_MAX - 1);

   state_t     state;
   state_t     next;
   logic [4:0] wait_cnt;
   logic       mem_st;
   logic       wait_hit;
   logic       funct_ok;
   logic       set_illegal;
   logic       set_timeout;

   assign mem_st   = (state == FETCH) || (state == MEM_RD) ||
                     (state == MEM_WR);
   assign wait_hit = (wait_cnt == WAIT_LAST) && !mem_ready;
   assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND) || (funct == FN_OR);
   assign state_o  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
      end else begin
         state <= next;
      end
   end

   // Staying in a memory state means the access is still stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (mem_st && (next == state)) begin
         wait_cnt <= wait_cnt + 5'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
         timeout <= 1'b0;
      end else begin
         illegal <= illegal | set_illegal;
         timeout <= timeout | set_timeout;
      end
   end

   always_comb begin
      next        = state;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      unique case (state)
         INIT: next = FETCH;
         FETCH: begin
            if (mem_ready) begin
               next = DECODE;
            end else if (wait_hit) begin
               next        = TRAP;
               set_timeout = 1'b1;
            end
         end
         DECODE: begin
            unique case (1'b1)
               (opcode == OP_RTYPE) && funct_ok: next = EXEC;
               (opcode == OP_LW):                next = MEM_ADDR;
               (opcode == OP_SW):                next = MEM_ADDR;
               (opcode == OP_BEQ):               next = BRANCH;
               (opcode == OP_J):                 next = JUMP;
               (opcode == OP_ADDI):              next = ADDI_EX;
               default: begin
                  next        = TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         MEM_ADDR: next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (mem_ready) begin
               next = MEM_WB;
            end else if (wait_hit) begin
               next        = TRAP;
               set_timeout = 1'b1;
            end
         end
         MEM_WB: next = FETCH;
         MEM_WR: begin
            if (mem_ready) begin
               next = FETCH;
            end else if (wait_hit) begin
               next        = TRAP;
               set_timeout = 1'b1;
            end
         end
         EXEC:    next = ALU_WB;
         ALU_WB:  next = FETCH;
         BRANCH:  next = FETCH;
         JUMP:    next = FETCH;
         ADDI_EX: next = ADDI_WB;
         ADDI_WB: next = FETCH;
         TRAP:    next = TRAP;
         default: next = TRAP;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_con       = 2'b11;
      pc_source     = 2'b00;
      unique case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_con   = PC_INC_CON;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            alu_con   = PC_INC_CON;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_con   = PC_INC_CON;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            unique case (1'b1)
               (funct == FN_SUB): alu_con = 2'b10;
               (funct == FN_AND): alu_con = 2'b00;
               (funct == FN_OR):  alu_con = 2'b01;
               default:           alu_con = 2'b11;
            endcase
         end
         ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_con       = 2'b10;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_con   = PC_INC_CON;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: random instruction mix with random memory
// latency against an instruction-level model, plus directed trap/reset cases.
module tb_mc_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_con;
   logic [1:0] pc_source;
   logic       illegal;
   logic       timeout;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;

   typedef struct {
      int   st;
      logic rdy;
   } step_t;

   step_t q[$];

   mc_ctrl #(.WAIT_MAX(16), .PC_INC_CON(2'b11)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_con(alu_con),
      .pc_source(pc_source), .illegal(illegal), .timeout(timeout),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [15:0] outs = {pc_write, pc_write_cond, i_or_d, mem_read,
                       mem_write, ir_write, mem_to_reg, reg_dst,
                       reg_write, alu_src_a, alu_src_b, alu_con,
                       pc_source};

   // Control word expected in a given state, straight from the state table.
   function automatic logic [15:0] exp_out(input int st, input logic rdy,
                                           input logic [5:0] fn);
      logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
      logic [1:0] sb, ac, ps;
      {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
      sb = 2'b00; ac = 2'b11; ps = 2'b00;
      case (st)
         1:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
         2:  sb = 2'b11;
         3:  begin sa = 1; sb = 2'b10; end
         4:  begin mr = 1; iod = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = 1; iod = 1; end
         7:  begin
            sa = 1;
            if (fn == 6'b100010) ac = 2'b10;
            else if (fn == 6'b100100) ac = 2'b00;
            else if (fn == 6'b100101) ac = 2'b01;
            else ac = 2'b11;
         end
         8:  begin rw = 1; rd = 1; end
         9:  begin sa = 1; ac = 2'b10; pwc = 1; ps = 2'b01; end
         10: begin pw = 1; ps = 2'b10; end
         11: begin sa = 1; sb = 2'b10; end
         12: rw = 1;
         default: ;
      endcase
      return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ac, ps};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input int st, input logic rdy,
                          input logic [5:0] fn, input logic [1:0] flags);
      chk({tag, "_st"}, 32'(state_o), 32'(st));
      chk({tag, "_out"}, 32'(outs), 32'(exp_out(st, rdy, fn)));
      chk({tag, "_flg"}, 32'({illegal, timeout}), 32'(flags));
   endtask

   task automatic drive(input logic r, input logic [5:0] op,
                        input logic [5:0] fn);
      @(negedge clk);
      mem_ready = r;
      opcode    = op;
      funct     = fn;
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk_cyc({tag, "_rst"}, 0, 1'b0, 6'd0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_cyc({tag, "_init"}, 0, 1'b0, 6'd0, 2'b00);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected state walk of one instruction given its fetch/memory stalls.
   task automatic run_instr(input string tag, input logic [5:0] op,
                            input logic [5:0] fn, input int flat,
                            input int mlat);
      q.delete();
      for (int i = 0; i < flat; i++) q.push_back('{1, 1'b0});
      q.push_back('{1, 1'b1});
      q.push_back('{2, rnd_bit()});
      if (op == 6'd0) begin
         q.push_back('{7, rnd_bit()});
         q.push_back('{8, rnd_bit()});
      end else if (op == LW || op == SW) begin
         q.push_back('{3, rnd_bit()});
         for (int i = 0; i < mlat; i++)
            q.push_back('{(op == LW) ? 4 : 6, 1'b0});
         q.push_back('{(op == LW) ? 4 : 6, 1'b1});
         if (op == LW) q.push_back('{5, rnd_bit()});
      end else if (op == BEQ) begin
         q.push_back('{9, rnd_bit()});
      end else if (op == JMP) begin
         q.push_back('{10, rnd_bit()});
      end else begin
         q.push_back('{11, rnd_bit()});
         q.push_back('{12, rnd_bit()});
      end
      foreach (q[i]) begin
         drive(q[i].rdy, op, fn);
         chk_cyc($sformatf("%s_c%0d", tag, i), q[i].st, q[i].rdy, fn,
                 2'b00);
      end
   endtask

   function automatic int rnd_lat();
      return ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [5:0] ops[6];
      logic [5:0] fns[4];
      logic [5:0] op;
      logic [5:0] fn;
      ops = '{6'd0, LW, SW, BEQ, JMP, ADDI};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
      rst_n     = 1'b0;
      opcode    = 6'd0;
      funct     = 6'd0;
      mem_ready = 1'b0;

      do_reset("r0");
      run_instr("add", 6'd0, 6'b100000, 0, 0);
      run_instr("lw3", LW, 6'd0, 2, 2);
      run_instr("sub", 6'd0, 6'b100010, 0, 0);
      run_instr("and", 6'd0, 6'b100100, 1, 0);
      run_instr("or", 6'd0, 6'b100101, 0, 0);
      run_instr("beq", BEQ, 6'd0, 0, 0);
      run_instr("sw15", SW, 6'd0, 15, 15);

      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 5)];
         fn = (op == 6'd0) ? fns[$urandom_range(0, 3)]
                           : 6'($urandom_range(0, 63));
         run_instr($sformatf("rnd%0d", n), op, fn, rnd_lat(), rnd_lat());
      end

      do_reset("r1");
      drive(1'b1, 6'b111111, 6'd0);
      chk_cyc("ill_f", 1, 1'b1, 6'd0, 2'b00);
      drive(1'b0, 6'b111111, 6'd0);
      chk_cyc("ill_d", 2, 1'b0, 6'd0, 2'b00);
      for (int i = 0; i < 20; i++) begin
         drive(rnd_bit(), 6'b111111, 6'd0);
         chk_cyc($sformatf("ill_t%0d", i), 13, 1'b0, 6'd0, 2'b10);
      end

      do_reset("r2");
      drive(1'b1, 6'd0, 6'b000111);
      chk_cyc("fn_f", 1, 1'b1, 6'b000111, 2'b00);
      drive(1'b1, 6'd0, 6'b000111);
      chk_cyc("fn_d", 2, 1'b1, 6'b000111, 2'b00);
      for (int i = 0; i < 20; i++) begin
         drive(rnd_bit(), 6'd0, 6'b100000);
         chk_cyc($sformatf("fn_t%0d", i), 13, 1'b0, 6'd0, 2'b10);
      end

      do_reset("r3");
      drive(1'b1, SW, 6'd0);
      drive(1'b0, SW, 6'd0);
      drive(1'b0, SW, 6'd0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, SW, 6'd0);
         chk_cyc($sformatf("to_w%0d", i), 6, 1'b0, 6'd0, 2'b00);
      end
      drive(1'b1, SW, 6'd0);
      chk_cyc("to_trap", 13, 1'b1, 6'd0, 2'b01);
      drive(1'b1, SW, 6'd0);
      chk_cyc("to_hold", 13, 1'b1, 6'd0, 2'b01);

      do_reset("r4");
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, LW, 6'd0);
         chk_cyc($sformatf("tof_w%0d", i), 1, 1'b0, 6'd0, 2'b00);
      end
      drive(1'b1, LW, 6'd0);
      chk_cyc("tof_trap", 13, 1'b1, 6'd0, 2'b01);

      do_reset("r5");
      run_instr("sw_edge", SW, 6'd0, 0, 15);

      do_reset("r6");
      drive(1'b1, SW, 6'd0);
      drive(1'b0, SW, 6'd0);
      drive(1'b0, SW, 6'd0);
      drive(1'b0, SW, 6'd0);
      chk_cyc("ar_pre", 6, 1'b0, 6'd0, 2'b00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_mw", 32'(mem_write), 32'd0);
      chk_cyc("ar_rst", 0, 1'b0, 6'd0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_cyc("ar_init", 0, 1'b0, 6'd0, 2'b00);
      drive(1'b0, SW, 6'd0);
      chk_cyc("ar_fetch", 1, 1'b0, 6'd0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
